// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// the register-zero constant and the packed bundle of pipeline controls.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Wide enough for the largest allowed memory timeout (65535).
  localparam int TIMER_W = 16;

  // Write enables and flushes for the PC, IF/ID and ID/EX registers.
  // The IF/ID and ID/EX register wrappers take the same bundle.
  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExWrite;
    logic idExFlush;
  } ctrl_t;

  // Normal flow: everything advances, nothing is cleared.
  localparam ctrl_t CTRL_RUN = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifIdFlush: 1'b0,
                                 idExWrite: 1'b1, idExFlush: 1'b0};
  // Reset: hold the front end and clear both pipeline registers.
  localparam ctrl_t CTRL_RESET = '{pcWrite: 1'b0, ifIdWrite: 1'b0, ifIdFlush: 1'b1,
                                   idExWrite: 1'b0, idExFlush: 1'b1};
  // Memory freeze: nothing moves and nothing is cleared.
  localparam ctrl_t CTRL_FREEZE = '{pcWrite: 1'b0, ifIdWrite: 1'b0, ifIdFlush: 1'b0,
                                    idExWrite: 1'b0, idExFlush: 1'b0};
  // Taken branch: fetch the target and squash both wrong-path slots.
  localparam ctrl_t CTRL_BRANCH = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifIdFlush: 1'b1,
                                    idExWrite: 1'b1, idExFlush: 1'b1};
  // Load-use stall: hold PC and IF/ID, push a bubble into ID/EX.
  localparam ctrl_t CTRL_STALL = '{pcWrite: 1'b0, ifIdWrite: 1'b0, ifIdFlush: 1'b0,
                                   idExWrite: 1'b1, idExFlush: 1'b1};

  // True when a used source operand names the non-zero destination of the load in EX.
  function automatic logic regMatch(input logic [4:0] exRd, input logic [4:0] src,
                                    input logic uses);
    return uses & (src == exRd) & (exRd != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count up on each enabled cycle but never wrap past all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and
// data-memory freeze, plus saturating performance counters and a sticky
// memory-timeout flag.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             mem_err
);

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(MEM_TIMEOUT);

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_memErr;

  logic               w_freeze;
  logic               w_loadUse;
  ctrl_t              w_ctrl;
  logic               w_incStall;
  logic               w_incFlush;
  logic               w_incWait;
  logic [TIMER_W-1:0] w_timerNext;

  assign w_freeze  = mem_req & ~mem_ready;
  assign w_loadUse = ex_MemRead &
                     (regMatch(ex_rd, id_rs1, id_uses_rs1) |
                      regMatch(ex_rd, id_rs2, id_uses_rs2));

  // Priority encode the hazards; only the winning condition is counted.
  always_comb begin
    w_ctrl     = CTRL_RUN;
    w_incStall = 1'b0;
    w_incFlush = 1'b0;
    w_incWait  = 1'b0;
    if (reset) begin
      w_ctrl = CTRL_RESET;
    end else if (w_freeze) begin
      w_ctrl    = CTRL_FREEZE;
      w_incWait = 1'b1;
    end else if (ex_branch_taken) begin
      w_ctrl     = CTRL_BRANCH;
      w_incFlush = 1'b1;
    end else if (w_loadUse) begin
      w_ctrl     = CTRL_STALL;
      w_incStall = 1'b1;
    end
  end

  // Next wait-timer value: starts at 1 on entering a freeze, counts up
  // while frozen and sticks at the timeout, clears once memory releases.
  always_comb begin
    w_timerNext = '0;
    if (w_freeze) begin
      if (r_state == RUN) begin
        w_timerNext = TIMER_W'(1);
      end else if (r_timer >= TIMEOUT_VAL) begin
        w_timerNext = TIMEOUT_VAL;
      end else begin
        w_timerNext = r_timer + TIMER_W'(1);
      end
    end
  end

  // Track RUN/MEM_WAIT, the wait timer and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_timer  <= '0;
      r_memErr <= 1'b0;
    end else begin
      r_timer <= w_timerNext;
      case (r_state)
        RUN:      r_state <= w_freeze ? MEM_WAIT : RUN;
        MEM_WAIT: r_state <= w_freeze ? MEM_WAIT : RUN;
        default:  r_state <= RUN;
      endcase
      if (w_freeze && (w_timerNext == TIMEOUT_VAL)) begin
        r_memErr <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_incStall),
    .o_count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_incFlush),
    .o_count (flush_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_waitCnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_incWait),
    .o_count (wait_cnt)
  );

  assign pc_write    = w_ctrl.pcWrite;
  assign if_id_write = w_ctrl.ifIdWrite;
  assign if_id_flush = w_ctrl.ifIdFlush;
  assign id_ex_write = w_ctrl.idExWrite;
  assign id_ex_flush = w_ctrl.idExFlush;
  assign mem_err     = r_memErr;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with a short timeout and 2-bit
// counters so timeout and saturation are reachable in a few cycles.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 2;

  // Expected control bundles {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush}
  localparam logic [4:0] C_NORM = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b11111;
  localparam logic [4:0] C_LU   = 5'b00011;
  localparam logic [4:0] C_FRZ  = 5'b00000;
  localparam logic [4:0] C_RST  = 5'b00101;

  typedef struct {
    int         vec;
    logic [4:0] ctrl;
    int         stall;
    int         flush;
    int         waitC;
    logic       err;
  } expect_t;

  logic             clk;
  logic             reset;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_MemRead;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err;

  expect_t scoreQ[$];
  int      total = 0;
  int      bad   = 0;
  int      vecNum = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_MemRead      (ex_MemRead),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .wait_cnt        (wait_cnt),
    .mem_err         (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string name, input int idx, input int actual,
                             input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL v%0d %s got=%0h expected=%0h", idx, name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue its expected response.
  task automatic applyStimulus(input logic rst, input int rs1, input int rs2,
                               input logic u1, input logic u2, input logic mr,
                               input int rd, input logic bt, input logic req,
                               input logic rdy, input logic [4:0] eCtrl,
                               input int eS, input int eF, input int eW,
                               input logic eE);
    expect_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    id_rs1          = 5'(rs1);
    id_rs2          = 5'(rs2);
    id_uses_rs1     = u1;
    id_uses_rs2     = u2;
    ex_MemRead      = mr;
    ex_rd           = 5'(rd);
    ex_branch_taken = bt;
    mem_req         = req;
    mem_ready       = rdy;
    vecNum++;
    e.vec   = vecNum;
    e.ctrl  = eCtrl;
    e.stall = eS;
    e.flush = eF;
    e.waitC = eW;
    e.err   = eE;
    scoreQ.push_back(e);
  endtask

  // Monitor: the controls are valid every cycle, so sample mid-cycle and
  // retire one scoreboard entry per cycle.
  always @(negedge clk) begin
    expect_t e;
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      checkOutput("ctrl", e.vec,
                  int'({pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush}),
                  int'(e.ctrl));
      checkOutput("stall_cnt", e.vec, int'(stall_cnt), e.stall);
      checkOutput("flush_cnt", e.vec, int'(flush_cnt), e.flush);
      checkOutput("wait_cnt", e.vec, int'(wait_cnt), e.waitC);
      checkOutput("mem_err", e.vec, int'(mem_err), int'(e.err));
    end
  end

  // Directed vectors; counters expected are the values visible in that cycle.
  initial begin
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_MemRead = 0; ex_rd = '0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    //             rst rs1 rs2 u1 u2 mr rd bt rq rdy ctrl    S  F  W  err
    applyStimulus(1,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_RST,  0, 0, 0, 0);
    applyStimulus(1,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_RST,  0, 0, 0, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 0, 0, 0, 0);
    // x0 destination never stalls; unused rs2 never stalls
    applyStimulus(0,  0,  0,  1, 0, 1, 0, 0, 0, 0,  C_NORM, 0, 0, 0, 0);
    applyStimulus(0,  3,  7,  1, 0, 1, 7, 0, 0, 0,  C_NORM, 0, 0, 0, 0);
    // load-use on rs1, then on rs2
    applyStimulus(0,  5,  0,  1, 0, 1, 5, 0, 0, 0,  C_LU,   0, 0, 0, 0);
    applyStimulus(0,  5,  0,  1, 0, 0, 5, 0, 0, 0,  C_NORM, 1, 0, 0, 0);
    applyStimulus(0,  0,  7,  0, 1, 1, 7, 0, 0, 0,  C_LU,   1, 0, 0, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 2, 0, 0, 0);
    // taken branch overrides a matching load-use
    applyStimulus(0,  5,  0,  1, 0, 1, 5, 1, 0, 0,  C_BR,   2, 0, 0, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 2, 1, 0, 0);
    applyStimulus(1,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_RST,  2, 1, 0, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 0, 0, 0, 0);
    // 3-cycle freeze with a branch pending; branch flushes on release
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 1, 1, 0,  C_FRZ,  0, 0, 0, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 1, 1, 0,  C_FRZ,  0, 0, 1, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 1, 1, 0,  C_FRZ,  0, 0, 2, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 1, 1, 1,  C_BR,   0, 0, 3, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 0, 1, 3, 0);
    // 6-cycle freeze: mem_err after the 4th cycle, wait_cnt saturated at 3
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  C_FRZ,  0, 1, 3, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  C_FRZ,  0, 1, 3, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  C_FRZ,  0, 1, 3, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  C_FRZ,  0, 1, 3, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  C_FRZ,  0, 1, 3, 1);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  C_FRZ,  0, 1, 3, 1);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 1, 1,  C_NORM, 0, 1, 3, 1);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 0, 1, 3, 1);
    applyStimulus(1,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_RST,  0, 1, 3, 1);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 0, 0, 0, 0);
    // freeze with a load-use present (not counted), then reset mid-freeze
    applyStimulus(0,  5,  0,  1, 0, 1, 5, 0, 1, 0,  C_FRZ,  0, 0, 0, 0);
    applyStimulus(0,  5,  0,  1, 0, 1, 5, 0, 1, 0,  C_FRZ,  0, 0, 1, 0);
    applyStimulus(1,  0,  0,  0, 0, 0, 0, 0, 1, 0,  C_RST,  0, 0, 2, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 0, 0, 0, 0);
    // five back-to-back stalls saturate the 2-bit stall counter at 3
    applyStimulus(0,  9,  0,  1, 0, 1, 9, 0, 0, 0,  C_LU,   0, 0, 0, 0);
    applyStimulus(0,  9,  0,  1, 0, 1, 9, 0, 0, 0,  C_LU,   1, 0, 0, 0);
    applyStimulus(0,  9,  0,  1, 0, 1, 9, 0, 0, 0,  C_LU,   2, 0, 0, 0);
    applyStimulus(0,  9,  0,  1, 0, 1, 9, 0, 0, 0,  C_LU,   3, 0, 0, 0);
    applyStimulus(0,  9,  0,  1, 0, 1, 9, 0, 0, 0,  C_LU,   3, 0, 0, 0);
    applyStimulus(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  C_NORM, 3, 0, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("queue_drain", vecNum, scoreQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
